// File: rtl/tdm_demux_16.sv
// tdm_demux_16: receive-side time-division demultiplexer for the 16-slot serial link.
// Collects one bit per valid beat into slots 0..15, starting at a frame-start marker.
// After each complete frame, the 16 bits appear on dout together with a one-cycle
// frame_valid pulse.
// Optional feature macro: FRAME_ERR_EN adds the registered frame_err pulse output.
module tdm_demux_16 #(
   parameter logic [15:0] DOUT_RST = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   input  logic        din_valid,
   input  logic        frame_start,
   output logic [15:0] dout,
   output logic        frame_valid,
   output logic [3:0]  sel,
   output logic        busy
`ifdef FRAME_ERR_EN
   ,
   output logic        frame_err
`endif
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   // Slot 15 is never stored here; it goes straight into dout with the frame.
   logic [14:0] shadow_q, shadow_d;
   logic [15:0] dout_q, dout_d;
   logic        frame_valid_q, frame_valid_d;
   logic        err_d;
`ifdef FRAME_ERR_EN
   logic        frame_err_q;
`endif

   // Next-state logic: slot capture, frame completion, resync and beat dropping.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      shadow_d      = shadow_q;
      dout_d        = dout_q;
      frame_valid_d = 1'b0;
      err_d         = 1'b0;
      if (din_valid) begin
         case (state_q)
            S_IDLE: begin
               if (frame_start) begin
                  shadow_d = {14'b0, din};
                  sel_d    = 4'd1;
                  state_d  = S_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               // A frame_start inside RUN always resyncs, even on the slot-15 beat.
               if (frame_start) begin
                  shadow_d = {14'b0, din};
                  sel_d    = 4'd1;
                  err_d    = 1'b1;
               end else if (sel_q == 4'd15) begin
                  dout_d        = {din, shadow_q};
                  frame_valid_d = 1'b1;
                  sel_d         = 4'd0;
                  state_d       = S_IDLE;
               end else begin
                  for (int unsigned i = 0; i < 15; i++) begin
                     if (sel_q == 4'(i)) shadow_d[i] = din;
                  end
                  sel_d = sel_q + 4'd1;
               end
            end
         endcase
      end
   end

   // State registers with synchronous active-high reset; reset also drops any beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sel_q         <= '0;
         shadow_q      <= '0;
         dout_q        <= DOUT_RST;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         shadow_q      <= shadow_d;
         dout_q        <= dout_d;
         frame_valid_q <= frame_valid_d;
      end
   end

`ifdef FRAME_ERR_EN
   // Registered error pulse for resyncs and for beats dropped in IDLE.
   always_ff @(posedge clk) begin
      if (rst) frame_err_q <= 1'b0;
      else     frame_err_q <= err_d;
   end
   assign frame_err = frame_err_q;
`else
   logic unused_err;
   assign unused_err = err_d;
`endif

   assign dout        = dout_q;
   assign frame_valid = frame_valid_q;
   assign sel         = sel_q;
   assign busy        = (state_q == S_RUN);

endmodule

// File: tb/tb_tdm_demux_16.sv
// Scoreboard bench for tdm_demux_16: expected frames are queued at stimulus time
// and checked by a monitor whenever frame_valid is seen.
module tb_tdm_demux_16;

   localparam logic [15:0] DRST = 16'h1234;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        frame_start = 1'b0;
   logic [15:0] dout;
   logic        frame_valid;
   logic [3:0]  sel;
   logic        busy;
`ifdef FRAME_ERR_EN
   logic        frame_err;
   int          err_cnt = 0;
`endif

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int pulses = 0;

   typedef struct {
      logic [15:0] data;
      int          at_cyc;
   } exp_t;
   exp_t exp_q[$];

   tdm_demux_16 #(.DOUT_RST(DRST)) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .din_valid(din_valid),
      .frame_start(frame_start),
      .dout(dout),
      .frame_valid(frame_valid),
      .sel(sel),
      .busy(busy)
`ifdef FRAME_ERR_EN
      ,
      .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every frame_valid cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         pulses++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_frame_valid: dout %h at cycle %0d, none expected", dout, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (dout !== e.data || cyc != e.at_cyc) begin
               miscompares++;
               $display("FAIL frame_out: dout %h at cycle %0d, expected %h at cycle %0d",
                        dout, cyc, e.data, e.at_cyc);
            end
         end
      end
`ifdef FRAME_ERR_EN
      if (frame_err === 1'b1) err_cnt++;
`endif
   end

   task automatic drive(input logic v, input logic fs, input logic d);
      @(negedge clk);
      din_valid   = v;
      frame_start = fs;
      din         = d;
      @(posedge clk);
      #1;
   endtask

   // Sends a full frame LSB first; optional 3-cycle gaps after slots 4 and 11.
   task automatic send_frame(input logic [15:0] data, input bit gaps, input logic [15:0] prev);
      for (int s = 0; s < 16; s++) begin
         if (s == 15) begin
            exp_t e;
            e.data   = data;
            e.at_cyc = cyc + 1;
            exp_q.push_back(e);
         end
         drive(1'b1, s == 0, data[s]);
         if (s < 15) begin
            check("sel_step", {12'b0, sel}, 16'(s + 1));
            check("busy_run", {15'b0, busy}, 16'd1);
            check("dout_hold", dout, prev);
         end
         if (gaps && (s == 4 || s == 11)) begin
            for (int g = 0; g < 3; g++) begin
               drive(1'b0, 1'b0, 1'b1);
               check("sel_gap", {12'b0, sel}, 16'(s + 1));
            end
         end
      end
      check("dout_frame", dout, data);
      check("sel_wrap", {12'b0, sel}, 16'd0);
      check("busy_idle", {15'b0, busy}, 16'd0);
   endtask

   initial begin
`ifdef FRAME_ERR_EN
      int err_base;
`endif
      // Reset, with a valid beat present that must be dropped.
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      check("rst_dout", dout, DRST);
      check("rst_sel", {12'b0, sel}, 16'd0);
      check("rst_busy", {15'b0, busy}, 16'd0);
      check("rst_fv", {15'b0, frame_valid}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      din_valid = 1'b0;

      // Plain frame, then the same frame with gaps.
      send_frame(16'hA5C3, 1'b0, DRST);
      drive(1'b0, 1'b0, 1'b0);
      send_frame(16'hA5C3, 1'b1, 16'hA5C3);
      drive(1'b0, 1'b0, 1'b0);

      // Back-to-back frames with no idle cycle.
      send_frame(16'h0001, 1'b0, 16'hA5C3);
      send_frame(16'h8000, 1'b0, 16'h0001);
      drive(1'b0, 1'b0, 1'b0);

      // Partial frame up to sel 7, then resync into a full frame.
`ifdef FRAME_ERR_EN
      err_base = err_cnt;
`endif
      for (int s = 0; s < 7; s++) drive(1'b1, s == 0, 1'b0);
      check("pre_resync_sel", {12'b0, sel}, 16'd7);
      send_frame(16'hFFFF, 1'b0, 16'h8000);
      drive(1'b0, 1'b0, 1'b0);
`ifdef FRAME_ERR_EN
      check("err_resync", 16'(err_cnt - err_base), 16'd1);
`endif

      // Valid beats in IDLE without a marker are dropped.
`ifdef FRAME_ERR_EN
      err_base = err_cnt;
`endif
      for (int s = 0; s < 5; s++) begin
         drive(1'b1, 1'b0, 1'b1);
         check("drop_sel", {12'b0, sel}, 16'd0);
         check("drop_busy", {15'b0, busy}, 16'd0);
      end
      drive(1'b0, 1'b0, 1'b0);
      check("drop_dout", dout, 16'hFFFF);
`ifdef FRAME_ERR_EN
      check("err_drop", 16'(err_cnt - err_base), 16'd5);
`endif

      // Reset mid-frame at sel 9, with a simultaneous valid beat.
      for (int s = 0; s < 9; s++) drive(1'b1, s == 0, 1'b1);
      check("pre_rst_sel", {12'b0, sel}, 16'd9);
      @(negedge clk);
      rst = 1'b1;
      din_valid = 1'b1;
      frame_start = 1'b0;
      din = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_sel", {12'b0, sel}, 16'd0);
      check("midrst_dout", dout, DRST);
      check("midrst_busy", {15'b0, busy}, 16'd0);
      check("midrst_fv", {15'b0, frame_valid}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      din_valid = 1'b0;
      for (int s = 0; s < 4; s++) drive(1'b0, 1'b0, 1'b0);

      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      check("pulse_count", 16'(pulses), 16'd5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tdm_demux_16.md
# tdm_demux_16

Time-division demultiplexer for the receive end of the 16-slot serial link driven by the 16:1 mux path. It accepts one bit per valid beat and assigns slot numbers 0..15 from a 4-bit slot counter synchronised by a frame-start marker. After each complete frame it presents all 16 bits on a parallel register with a one-cycle valid pulse. It sits between the serial link and the parallel consumer logic.

## Interface
- `DOUT_RST`, default 16'h0000: reset and clear value of `dout`.
- `clk`  input  1  system clock; all logic updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  1  serial data bit for the current slot.
- `din_valid`  input  1  `din` is a valid beat this cycle.
- `frame_start`  input  1  qualifies the current valid beat as slot 0; ignored when `din_valid` is low.
- `dout`  output  16  last complete frame; `dout[k]` is the bit received in slot k.
- `frame_valid`  output  1  one-cycle pulse indicating that `dout` has just been updated.
- `sel`  output  4  slot number the next valid beat will be written to.
- `busy`  output  1  a frame is in progress (state RUN).
- `frame_err`  output  1  one-cycle error pulse; exists only with `FRAME_ERR_EN`, see Configuration.

## Operation
- **Reset.** While `rst` is high at a clock edge:
  - state becomes IDLE; `sel` = 0; shadow register = 0;
  - `dout` = `DOUT_RST`; `frame_valid` = 0; `busy` = 0; `frame_err` = 0.
  - Reset mid-frame discards the partial frame, and no `frame_valid` is issued for it.
- **State IDLE** (waiting for frame start):
  - `din_valid` & `frame_start`: shadow = 0, then shadow[0] = `din`; `sel` = 1; go to RUN.
  - `din_valid` & !`frame_start`: beat dropped; state, `sel` and shadow unchanged.
- **State RUN** (frame in progress):
  - `din_valid` low: hold everything. Gaps of any length are allowed.
  - `din_valid` & !`frame_start` & `sel` < 15: shadow[`sel`] = `din`; `sel` = `sel` + 1.
  - `din_valid` & !`frame_start` & `sel` == 15 (last slot):
    - `dout` = {`din`, shadow[14:0]}; `frame_valid` = 1 next cycle;
    - `sel` wraps to 0; go to IDLE.
  - `din_valid` & `frame_start` at any `sel` other than 0 (resync):
    - partial frame discarded; shadow = 0; shadow[0] = `din`; `sel` = 1; stay in RUN;
    - `dout` unchanged; no `frame_valid`.
- **Every frame needs its own marker.** Frames do not chain automatically; each new frame requires `frame_start` on its slot-0 beat.
- **`busy`** is high exactly while in RUN.
- **Other outputs.**
  - `dout` is held between frames.
  - `sel` is a registered 4-bit counter.
  - Unused input combinations have no effect.

## Timing
- Capture: a beat accepted at edge N is reflected in `sel` at edge N.
- Output latency: the slot-15 beat accepted at edge N updates `dout` at edge N, and `frame_valid` is high for the cycle N..N+1.
- Back-to-back frames: `frame_start` may arrive on the beat immediately after slot 15. That beat is accepted from IDLE with zero dead cycles.
- Throughput: 16 beats per frame, at most one beat per cycle.
- Simultaneous reset and `din_valid`: reset wins, and the beat is dropped.

## Configuration
- `FRAME_ERR_EN` defined:
  - `frame_err` port present, registered, reset to 0.
  - It pulses high for one cycle after either of two events:
    - a resync (`frame_start` while in RUN);
    - a valid beat in IDLE without `frame_start`.
  - Data behaviour is identical to the undefined case.
- `FRAME_ERR_EN` undefined:
  - `frame_err` port and its logic are absent.
  - Resyncs and dropped beats are silent.

## Test plan
- Reset, then 16 consecutive beats with `frame_start` on the first beat and data 16'hA5C3 sent LSB first (slot 0 first) -> one cycle after the last beat, `dout` = 16'hA5C3, `frame_valid` high for one cycle, `sel` = 0, `busy` = 0.
- Same frame with `din_valid` dropped low for 3 cycles after slots 4 and 11 -> `dout` = 16'hA5C3; `sel` holds during the gaps.
- Two frames back-to-back (16'h0001, then 16'h8000) with no idle cycle -> two `frame_valid` pulses 16 cycles apart; `dout` = 16'h0001, then 16'h8000.
- `frame_start` reasserted at `sel` = 7, followed by a full 16'hFFFF frame -> `dout` keeps its prior value until the frame completes, then becomes 16'hFFFF; with `FRAME_ERR_EN`, `frame_err` pulses once.
- 5 valid beats without `frame_start` from IDLE -> `sel` = 0, `busy` = 0, no `frame_valid`; with `FRAME_ERR_EN`, 5 `frame_err` pulses.
- `rst` asserted at `sel` = 9 -> next cycle `sel` = 0, `dout` = `DOUT_RST`, `busy` = 0, and no `frame_valid` for the aborted frame.
